sc_spi_slv: RTL and testbench

SC_SPI_SLV -- requirements
Module: sc_spi_slv

---
 rtl/sc_spi_slv.sv | 192 +++++++++++++++++++
 tb/tb_sc_spi_slv.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sc_spi_slv.sv
// SPI slave with pin synchronizers, all four modes, 1..32-bit words, MSB/LSB first, one-word TX buffer.
// Latency: pin-to-edge detect SYNC_STAGES+1 SYSCLK cycles; RXDATA/RXVALID one cycle after the last sample edge.
// Backpressure: TX via TXVALID/TXREADY into a single buffer; RX has none (missed RXVALID loses the word).
module sc_spi_slv #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        SYSCLK,
    input  logic        SYSRSTB,
    input  logic        CPOL,
    input  logic        CPHA,
    input  logic        BORDER,
    input  logic [4:0]  DWIDTH,
    input  logic        SPI_SCLK,
    input  logic        SPI_CSB,
    input  logic        SPI_MOSI,
    output logic        SPI_MISO,
    output logic        SPI_MISO_OE,
    input  logic [31:0] TXDATA,
    input  logic        TXVALID,
    output logic        TXREADY,
    output logic [31:0] RXDATA,
    output logic        RXVALID,
    output logic        SPIBUSY,
    output logic        TXUNDERRUN,
    output logic        RXABORT
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    logic [SYNC_STAGES-1:0] sclk_sync, csb_sync, mosi_sync;
    logic        sclk_hist, csb_hist;
    logic        sclk_s, csb_s, mosi_s;
    logic [1:0]  fill_cnt;
    logic        armed;

    logic [1:0]  state;
    logic        cpol_l, cpha_l, border_l;
    logic [4:0]  dwidth_l;
    logic [31:0] tx_buf, tx_sr, rx_sr, rx_next, load_word;
    logic        buf_full, reload_pend, miso_r;
    logic [4:0]  bit_cnt, ptr, first_ptr;
    logic        sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
    logic        csb_fall, in_shift, word_done, tx_load;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign csb_s  = csb_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Pin synchronizers plus one history flop for edge detection
    always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            sclk_sync <= '0;
            csb_sync  <= '1;
            mosi_sync <= '0;
            sclk_hist <= 1'b0;
            csb_hist  <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_SCLK};
            csb_sync  <= {csb_sync[SYNC_STAGES-2:0], SPI_CSB};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
            sclk_hist <= sclk_s;
            csb_hist  <= csb_s;
        end
    end

    // Arm frame start only after the synchronizer has flushed and CSB was seen high,
    // so a CSB already low at reset release is not mistaken for a fresh select
    always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            fill_cnt <= 2'd0;
            armed    <= 1'b0;
        end else begin
            if (fill_cnt != 2'(SYNC_STAGES))
                fill_cnt <= fill_cnt + 2'd1;
            else if (csb_s)
                armed <= 1'b1;
        end
    end

    assign sclk_rise   = sclk_s & ~sclk_hist;
    assign sclk_fall   = ~sclk_s & sclk_hist;
    assign csb_fall    = ~csb_s & csb_hist;
    assign lead_edge   = cpol_l ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol_l ? sclk_rise : sclk_fall;
    assign sample_edge = cpha_l ? trail_edge : lead_edge;
    assign shift_edge  = cpha_l ? lead_edge : trail_edge;

    assign ptr       = border_l ? (dwidth_l - bit_cnt) : bit_cnt;
    assign first_ptr = border_l ? dwidth_l : 5'd0;
    assign load_word = buf_full ? tx_buf : 32'd0;
    assign in_shift  = (state == ST_SHIFT) && !csb_s;
    assign word_done = in_shift && sample_edge && (bit_cnt == dwidth_l);
    // The reload after a completed word is deferred to the next shift edge, which is
    // exactly when the next word's first bit must appear; if CSB rises first, no reload
    // (and no spurious underrun) happens.
    assign tx_load   = (state == ST_LOAD) || (in_shift && shift_edge && reload_pend);

    // Insert the sampled MOSI bit at its word position (upper unused bits stay 0)
    always_comb begin
        rx_next      = rx_sr;
        rx_next[ptr] = mosi_s;
    end

    // Transfer FSM, shift registers, status pulses and TX buffer
    always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            state       <= ST_IDLE;
            cpol_l      <= 1'b0;
            cpha_l      <= 1'b0;
            border_l    <= 1'b0;
            dwidth_l    <= 5'd0;
            tx_buf      <= 32'd0;
            tx_sr       <= 32'd0;
            rx_sr       <= 32'd0;
            buf_full    <= 1'b0;
            reload_pend <= 1'b0;
            miso_r      <= 1'b0;
            bit_cnt     <= 5'd0;
            RXDATA      <= 32'd0;
            RXVALID     <= 1'b0;
            TXUNDERRUN  <= 1'b0;
            RXABORT     <= 1'b0;
        end else begin
            RXVALID    <= 1'b0;
            TXUNDERRUN <= 1'b0;
            RXABORT    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (csb_fall && armed) begin
                        cpol_l   <= CPOL;
                        cpha_l   <= CPHA;
                        border_l <= BORDER;
                        dwidth_l <= DWIDTH;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tx_sr       <= load_word;
                    TXUNDERRUN  <= ~buf_full;
                    bit_cnt     <= 5'd0;
                    rx_sr       <= 32'd0;
                    reload_pend <= 1'b0;
                    miso_r      <= cpha_l ? 1'b0 : load_word[first_ptr];
                    state       <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (csb_s) begin
                        state   <= ST_IDLE;
                        RXABORT <= (bit_cnt != 5'd0);
                    end else begin
                        if (sample_edge) begin
                            if (word_done) begin
                                RXDATA      <= rx_next;
                                RXVALID     <= 1'b1;
                                rx_sr       <= 32'd0;
                                bit_cnt     <= 5'd0;
                                reload_pend <= 1'b1;
                            end else begin
                                rx_sr   <= rx_next;
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                        if (shift_edge) begin
                            if (reload_pend) begin
                                tx_sr       <= load_word;
                                TXUNDERRUN  <= ~buf_full;
                                reload_pend <= 1'b0;
                                miso_r      <= load_word[first_ptr];
                            end else begin
                                miso_r <= tx_sr[ptr];
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (tx_load)
                buf_full <= 1'b0;
            if (TXVALID && !buf_full) begin
                tx_buf   <= TXDATA;
                buf_full <= 1'b1;
            end
        end
    end

    assign TXREADY     = ~buf_full;
    assign SPIBUSY     = (state != ST_IDLE);
    assign SPI_MISO_OE = SPIBUSY;
    assign SPI_MISO    = SPIBUSY & miso_r;

endmodule

// File: tb/tb_sc_spi_slv.sv
// Directed bench for sc_spi_slv: an SPI master task drives frames, monitors count pulses.
// Expected values are hand-computed constants per scenario.
// Checks use immediate assertions and end with a single summary line.
module tb_sc_spi_slv;
    localparam int SYNC = 2;

    logic        SYSCLK, SYSRSTB, CPOL, CPHA, BORDER;
    logic [4:0]  DWIDTH;
    logic        SPI_SCLK, SPI_CSB, SPI_MOSI, SPI_MISO, SPI_MISO_OE;
    logic [31:0] TXDATA, RXDATA;
    logic        TXVALID, TXREADY, RXVALID, SPIBUSY, TXUNDERRUN, RXABORT;

    int checks = 0;
    int errors = 0;
    int rx_cnt = 0;
    int ur_cnt = 0;
    int ab_cnt = 0;
    logic [31:0] rx_log [64];
    int b_rx, b_ur, b_ab;
    logic [31:0] miso_w;

    sc_spi_slv #(.SYNC_STAGES(SYNC)) dut (
        .SYSCLK(SYSCLK), .SYSRSTB(SYSRSTB), .CPOL(CPOL), .CPHA(CPHA), .BORDER(BORDER),
        .DWIDTH(DWIDTH), .SPI_SCLK(SPI_SCLK), .SPI_CSB(SPI_CSB), .SPI_MOSI(SPI_MOSI),
        .SPI_MISO(SPI_MISO), .SPI_MISO_OE(SPI_MISO_OE), .TXDATA(TXDATA), .TXVALID(TXVALID),
        .TXREADY(TXREADY), .RXDATA(RXDATA), .RXVALID(RXVALID), .SPIBUSY(SPIBUSY),
        .TXUNDERRUN(TXUNDERRUN), .RXABORT(RXABORT)
    );

    initial begin
        SYSCLK = 1'b0;
        forever #5 SYSCLK = ~SYSCLK;
    end

    // Pulse monitors sample away from the active edge
    always @(negedge SYSCLK) begin
        if (RXVALID) begin
            rx_log[rx_cnt[5:0]] <= RXDATA;
            rx_cnt <= rx_cnt + 1;
        end
        if (TXUNDERRUN) ur_cnt <= ur_cnt + 1;
        if (RXABORT)    ab_cnt <= ab_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        @(posedge SYSCLK);
        b_rx = rx_cnt;
        b_ur = ur_cnt;
        b_ab = ab_cnt;
    endtask

    task automatic tx_write(input logic [31:0] d);
        int n;
        n = 0;
        @(negedge SYSCLK);
        TXDATA  = d;
        TXVALID = 1'b1;
        while (TXREADY !== 1'b1 && n < 2000) begin
            @(negedge SYSCLK);
            n++;
        end
        check("tx_accept", {31'd0, TXREADY}, 32'd1);
        @(negedge SYSCLK);
        TXVALID = 1'b0;
    endtask

    // SPI master: sends nsend of nbits bits of mosi_word, collects MISO in frame order
    task automatic spi_xfer(input logic cpol, input logic cpha, input logic border,
                            input logic [4:0] dw, input int nbits, input int nsend,
                            input logic [31:0] mosi_word, input int half, input logic rel_csb,
                            output logic [31:0] miso_word);
        int idx;
        miso_word = 32'd0;
        @(negedge SYSCLK);
        CPOL = cpol; CPHA = cpha; BORDER = border; DWIDTH = dw;
        SPI_SCLK = cpol;
        #(half);
        SPI_CSB = 1'b0;
        for (int i = 0; i < nsend; i++) begin
            idx = border ? (nbits - 1 - i) : i;
            if (!cpha) begin
                SPI_MOSI = mosi_word[idx];
                #(half);
                SPI_SCLK = ~cpol;
                if (border) miso_word = {miso_word[30:0], SPI_MISO};
                else        miso_word[i] = SPI_MISO;
                #(half);
                SPI_SCLK = cpol;
            end else begin
                #(half);
                SPI_SCLK = ~cpol;
                SPI_MOSI = mosi_word[idx];
                #(half);
                SPI_SCLK = cpol;
                if (border) miso_word = {miso_word[30:0], SPI_MISO};
                else        miso_word[i] = SPI_MISO;
            end
        end
        if (rel_csb) begin
            #(half);
            SPI_CSB = 1'b1;
            #(2 * half);
        end
    endtask

    initial begin
        SYSRSTB = 1'b0; CPOL = 1'b0; CPHA = 1'b0; BORDER = 1'b1; DWIDTH = 5'd7;
        SPI_SCLK = 1'b0; SPI_CSB = 1'b1; SPI_MOSI = 1'b0; TXDATA = 32'd0; TXVALID = 1'b0;

        // Reset state
        repeat (3) @(negedge SYSCLK);
        check("rst_txready", {31'd0, TXREADY}, 32'd1);
        check("rst_rxdata", RXDATA, 32'd0);
        check("rst_rxvalid", {31'd0, RXVALID}, 32'd0);
        check("rst_busy", {31'd0, SPIBUSY}, 32'd0);
        check("rst_oe", {31'd0, SPI_MISO_OE}, 32'd0);
        check("rst_miso", {31'd0, SPI_MISO}, 32'd0);
        check("rst_pulses", {30'd0, TXUNDERRUN, RXABORT}, 32'd0);
        SYSRSTB = 1'b1;
        repeat (10) @(negedge SYSCLK);

        // Mode 0, MSB first, 8 bits
        tx_write(32'hA5);
        check("a_txready_full", {31'd0, TXREADY}, 32'd0);
        snap();
        spi_xfer(1'b0, 1'b0, 1'b1, 5'd7, 8, 8, 32'h3C, 80, 1'b1, miso_w);
        check("a_miso", miso_w, 32'hA5);
        check("a_rxdata", RXDATA, 32'h3C);
        check("a_rxvalid_cnt", rx_cnt - b_rx, 32'd1);
        check("a_abort_cnt", ab_cnt - b_ab, 32'd0);
        check("a_busy_after", {31'd0, SPIBUSY}, 32'd0);

        // Mode 3, LSB first, 32 bits
        tx_write(32'h12345678);
        snap();
        spi_xfer(1'b1, 1'b1, 1'b0, 5'd31, 32, 32, 32'hDEADBEEF, 80, 1'b1, miso_w);
        check("b_miso", miso_w, 32'h12345678);
        check("b_rxdata", RXDATA, 32'hDEADBEEF);
        check("b_rxvalid_cnt", rx_cnt - b_rx, 32'd1);

        // Mode 1, two back-to-back 8-bit words, second TX word written during the first
        tx_write(32'h11);
        snap();
        fork
            spi_xfer(1'b0, 1'b1, 1'b1, 5'd7, 16, 16, 32'hABCD, 80, 1'b1, miso_w);
            tx_write(32'h22);
        join
        check("c_miso", miso_w, 32'h1122);
        check("c_rxvalid_cnt", rx_cnt - b_rx, 32'd2);
        check("c_rx_word0", rx_log[b_rx % 64], 32'hAB);
        check("c_rx_word1", rx_log[(b_rx + 1) % 64], 32'hCD);
        check("c_underrun_cnt", ur_cnt - b_ur, 32'd0);
        check("c_abort_cnt", ab_cnt - b_ab, 32'd0);

        // Empty TX buffer at select, 16 bits
        check("d_txready", {31'd0, TXREADY}, 32'd1);
        snap();
        spi_xfer(1'b0, 1'b1, 1'b1, 5'd15, 16, 16, 32'h8001, 80, 1'b1, miso_w);
        check("d_miso_zero", miso_w, 32'd0);
        check("d_underrun_cnt", ur_cnt - b_ur, 32'd1);
        check("d_rxdata", RXDATA, 32'h8001);
        check("d_rxvalid_cnt", rx_cnt - b_rx, 32'd1);

        // CSB released after 5 of 8 bits
        tx_write(32'h5A);
        snap();
        spi_xfer(1'b0, 1'b0, 1'b1, 5'd7, 8, 5, 32'hFF, 80, 1'b0, miso_w);
        check("e_busy_mid", {31'd0, SPIBUSY}, 32'd1);
        check("e_oe_mid", {31'd0, SPI_MISO_OE}, 32'd1);
        @(negedge SYSCLK);
        SPI_CSB = 1'b1;
        repeat (SYNC + 2) @(negedge SYSCLK);
        check("e_busy_off", {31'd0, SPIBUSY}, 32'd0);
        check("e_oe_off", {31'd0, SPI_MISO_OE}, 32'd0);
        check("e_miso_off", {31'd0, SPI_MISO}, 32'd0);
        repeat (5) @(negedge SYSCLK);
        check("e_abort_cnt", ab_cnt - b_ab, 32'd1);
        check("e_rxvalid_cnt", rx_cnt - b_rx, 32'd0);
        check("e_rxdata_kept", RXDATA, 32'h8001);
        check("e_txready", {31'd0, TXREADY}, 32'd1);

        // Reset mid-word at SCLK = SYSCLK/4, then a fresh frame
        spi_xfer(1'b0, 1'b0, 1'b1, 5'd7, 8, 4, 32'hF0, 20, 1'b0, miso_w);
        snap();
        @(negedge SYSCLK);
        SYSRSTB = 1'b0;
        #1;
        check("f_rst_busy", {31'd0, SPIBUSY}, 32'd0);
        check("f_rst_oe", {31'd0, SPI_MISO_OE}, 32'd0);
        check("f_rst_miso", {31'd0, SPI_MISO}, 32'd0);
        check("f_rst_rxdata", RXDATA, 32'd0);
        check("f_rst_txready", {31'd0, TXREADY}, 32'd1);
        repeat (3) @(negedge SYSCLK);
        SYSRSTB = 1'b1;
        repeat (10) @(negedge SYSCLK);
        check("f_no_start_csb_low", {31'd0, SPIBUSY}, 32'd0);
        check("f_no_pulses", (ab_cnt - b_ab) + (rx_cnt - b_rx) + (ur_cnt - b_ur), 32'd0);
        SPI_CSB = 1'b1;
        repeat (5) @(negedge SYSCLK);
        tx_write(32'h3C);
        snap();
        spi_xfer(1'b0, 1'b0, 1'b1, 5'd7, 8, 8, 32'h96, 80, 1'b1, miso_w);
        check("f_miso", miso_w, 32'h3C);
        check("f_rxdata", RXDATA, 32'h96);
        check("f_rxvalid_cnt", rx_cnt - b_rx, 32'd1);
        check("f_abort_cnt", ab_cnt - b_ab, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
